sr_input_conditioner: RTL

- Input-conditioning stage directly upstream of the SR latch on the Vaman board.
- Takes the raw set and reset switch/button inputs (asynchronous to Sys_Clk0, bouncy) and synchronizes both into the clk domain.
- Debounces each channel independently and emits clean levels, single-cycle rising-edge pulses and a both-asserted conflict flag.
- Outputs s_db/r_db drive the latch's s/r inputs.

---
 rtl/sr_input_conditioner.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sr_input_conditioner.sv
// Two-flop synchronizer plus per-channel debounce FSM for the SR latch set/reset inputs.
// Optional SR_COND_EVENT_CNT_EN builds 8-bit wrapping rise-event counters on s_cnt/r_cnt.
module sr_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_raw,
    input  logic       r_raw,
    output logic       s_db,
    output logic       r_db,
    output logic       s_rise,
    output logic       r_rise,
    output logic       conflict,
    output logic [7:0] s_cnt,
    output logic [7:0] r_cnt
);

    typedef enum logic [1:0] {StLow, StLowPend, StHigh, StHighPend} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    // Index 0 is the set channel, index 1 the reset channel.
    logic [1:0]       raw;
    logic [1:0]       ff1_q;
    logic [1:0]       sync_q;
    logic [1:0]       db_q;
    logic [1:0]       rise_q;
    state_e           state_q [2];
    logic [CNT_W-1:0] cnt_q   [2];

    assign raw = {r_raw, s_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_q  <= '0;
            sync_q <= '0;
        end else begin
            ff1_q  <= raw;
            sync_q <= ff1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q   <= '0;
            rise_q <= '0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StLow;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rise_q[i] <= 1'b0;
                unique case (state_q[i])
                    StLow: begin
                        if (sync_q[i]) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state_q[i] <= StHigh;
                                db_q[i]    <= 1'b1;
                                rise_q[i]  <= 1'b1;
                            end else begin
                                state_q[i] <= StLowPend;
                                cnt_q[i]   <= CntOne;
                            end
                        end
                    end
                    StLowPend: begin
                        if (!sync_q[i]) begin
                            state_q[i] <= StLow;
                            cnt_q[i]   <= '0;
                        end else if (cnt_q[i] == CntLast) begin
                            state_q[i] <= StHigh;
                            db_q[i]    <= 1'b1;
                            rise_q[i]  <= 1'b1;
                            cnt_q[i]   <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CntOne;
                        end
                    end
                    StHigh: begin
                        if (!sync_q[i]) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state_q[i] <= StLow;
                                db_q[i]    <= 1'b0;
                            end else begin
                                state_q[i] <= StHighPend;
                                cnt_q[i]   <= CntOne;
                            end
                        end
                    end
                    StHighPend: begin
                        if (sync_q[i]) begin
                            state_q[i] <= StHigh;
                            cnt_q[i]   <= '0;
                        end else if (cnt_q[i] == CntLast) begin
                            state_q[i] <= StLow;
                            db_q[i]    <= 1'b0;
                            cnt_q[i]   <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CntOne;
                        end
                    end
                    default: begin
                        state_q[i] <= StLow;
                        cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign s_db     = db_q[0];
    assign r_db     = db_q[1];
    assign s_rise   = rise_q[0];
    assign r_rise   = rise_q[1];
    assign conflict = db_q[0] & db_q[1];

`ifdef SR_COND_EVENT_CNT_EN
    logic [7:0] s_cnt_q;
    logic [7:0] r_cnt_q;

    // Counts each registered rise pulse; wraps 255 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_cnt_q <= '0;
            r_cnt_q <= '0;
        end else begin
            if (rise_q[0]) s_cnt_q <= s_cnt_q + 8'd1;
            if (rise_q[1]) r_cnt_q <= r_cnt_q + 8'd1;
        end
    end

    assign s_cnt = s_cnt_q;
    assign r_cnt = r_cnt_q;
`else
    assign s_cnt = 8'd0;
    assign r_cnt = 8'd0;
`endif

endmodule
